// File: rtl/ysyx_ifu_fetch_ctrl.sv
// ysyx_ifu_fetch_ctrl
//   Fetch-stage controller. Owns the fetch PC, presents it to the branch
//   predictor and the L1 instruction cache, and registers each returned
//   instruction into a single-entry slot toward the decoder. Handles backend
//   redirects, draining of a stale outstanding miss, fence.i invalidation
//   and fetch traps.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   bpu_pc / bpu_npc / bpu_taken : current fetch PC and its prediction
//   l1i_pc / l1i_invalid  : fetch address and invalidate-all pulse to L1I
//   l1i_inst / l1i_trap / l1i_cause / l1i_valid : L1I response for l1i_pc
//   idu_*                 : registered output slot toward the decoder
//   idu_ready             : decoder takes the slot this cycle
//   redirect_valid / redirect_pc / redirect_fence_i : backend redirect
module ysyx_ifu_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] bpu_pc,
  input  logic [XLEN-1:0] bpu_npc,
  input  logic            bpu_taken,
  output logic [XLEN-1:0] l1i_pc,
  output logic            l1i_invalid,
  input  logic [31:0]     l1i_inst,
  input  logic            l1i_trap,
  input  logic [XLEN-1:0] l1i_cause,
  input  logic            l1i_valid,
  output logic [31:0]     idu_inst,
  output logic [XLEN-1:0] idu_pc,
  output logic [XLEN-1:0] idu_pnpc,
  output logic            idu_trap,
  output logic [XLEN-1:0] idu_cause,
  output logic            idu_valid,
  input  logic            idu_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_fence_i
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_FENCE   = 2'd2,
    S_TRAPPED = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] tgt_pc_reg, tgt_pc_next;
  logic            fence_pend_reg, fence_pend_next;

  logic [31:0]     inst_reg, inst_next;
  logic [XLEN-1:0] slot_pc_reg, slot_pc_next;
  logic [XLEN-1:0] pnpc_reg, pnpc_next;
  logic            trap_reg, trap_next;
  logic [XLEN-1:0] cause_reg, cause_next;
  logic            valid_reg, valid_next;

  logic [XLEN-1:0] pnpc;
  logic            accept;
  logic            fence_req;

  assign bpu_pc      = pc_reg;
  assign l1i_pc      = pc_reg;
  assign l1i_invalid = (state_reg == S_FENCE);

  assign idu_inst  = inst_reg;
  assign idu_pc    = slot_pc_reg;
  assign idu_pnpc  = pnpc_reg;
  assign idu_trap  = trap_reg;
  assign idu_cause = cause_reg;
  assign idu_valid = valid_reg;

  always_comb begin
    pnpc   = bpu_taken ? bpu_npc : pc_reg + XLEN'(4);
    accept = (state_reg == S_FETCH) && !redirect_valid && l1i_valid &&
             (!valid_reg || idu_ready);
    // In FENCE the pending fence is being serviced this very cycle, so only
    // a fresh fence request on the redirect keeps the pulse going.
    fence_req = redirect_fence_i |
                ((state_reg == S_FENCE) ? 1'b0 : fence_pend_reg);

    state_next      = state_reg;
    pc_next         = pc_reg;
    tgt_pc_next     = tgt_pc_reg;
    fence_pend_next = fence_pend_reg;
    inst_next       = inst_reg;
    slot_pc_next    = slot_pc_reg;
    pnpc_next       = pnpc_reg;
    trap_next       = trap_reg;
    cause_next      = cause_reg;
    valid_next      = valid_reg;

    // Slot: load on accept, otherwise drain when the decoder takes it.
    if (accept) begin
      inst_next    = l1i_inst;
      slot_pc_next = pc_reg;
      pnpc_next    = pnpc;
      trap_next    = l1i_trap;
      cause_next   = l1i_cause;
      valid_next   = 1'b1;
    end else if (valid_reg && idu_ready) begin
      valid_next = 1'b0;
    end

    if (redirect_valid) begin
      valid_next      = 1'b0;
      tgt_pc_next     = redirect_pc;
      fence_pend_next = fence_req;
      unique case (state_reg)
        S_FETCH: begin
          if (!l1i_valid) begin
            // Request still in flight; wait for it before moving pc.
            state_next = S_DISCARD;
          end else begin
            pc_next    = redirect_pc;
            state_next = fence_req ? S_FENCE : S_FETCH;
          end
        end
        S_DISCARD: state_next = S_DISCARD;
        S_TRAPPED, S_FENCE: begin
          pc_next    = redirect_pc;
          state_next = fence_req ? S_FENCE : S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end else begin
      unique case (state_reg)
        S_FETCH: begin
          if (accept) begin
            if (l1i_trap) state_next = S_TRAPPED;
            else          pc_next    = pnpc;
          end
        end
        S_DISCARD: begin
          if (l1i_valid) begin
            pc_next    = tgt_pc_reg;
            state_next = fence_pend_reg ? S_FENCE : S_FETCH;
          end
        end
        S_FENCE: begin
          fence_pend_next = 1'b0;
          state_next      = S_FETCH;
        end
        S_TRAPPED: state_next = S_TRAPPED;
        default:   state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_FETCH;
      pc_reg         <= RESET_PC;
      tgt_pc_reg     <= RESET_PC;
      fence_pend_reg <= 1'b0;
      inst_reg       <= '0;
      slot_pc_reg    <= '0;
      pnpc_reg       <= '0;
      trap_reg       <= 1'b0;
      cause_reg      <= '0;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      tgt_pc_reg     <= tgt_pc_next;
      fence_pend_reg <= fence_pend_next;
      inst_reg       <= inst_next;
      slot_pc_reg    <= slot_pc_next;
      pnpc_reg       <= pnpc_next;
      trap_reg       <= trap_next;
      cause_reg      <= cause_next;
      valid_reg      <= valid_next;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_fetch_ctrl.sv
// tb_ysyx_ifu_fetch_ctrl
//   Directed scenarios for the fetch controller. Inputs are driven 1 ns
//   after each rising edge; outputs are checked at the same point.
module tb_ysyx_ifu_fetch_ctrl;

  localparam logic [31:0] RST = 32'h8000_0000;
  localparam logic [31:0] K   = 32'h0000_5a5a;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bpu_pc, bpu_npc, l1i_pc, l1i_cause, idu_pc, idu_pnpc, idu_cause, redirect_pc;
  logic        bpu_taken, l1i_invalid, l1i_trap, l1i_valid, idu_trap, idu_valid;
  logic        idu_ready, redirect_valid, redirect_fence_i;
  logic [31:0] l1i_inst, idu_inst;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  ysyx_ifu_fetch_ctrl dut (
    .clock(clock), .reset(reset),
    .bpu_pc(bpu_pc), .bpu_npc(bpu_npc), .bpu_taken(bpu_taken),
    .l1i_pc(l1i_pc), .l1i_invalid(l1i_invalid), .l1i_inst(l1i_inst),
    .l1i_trap(l1i_trap), .l1i_cause(l1i_cause), .l1i_valid(l1i_valid),
    .idu_inst(idu_inst), .idu_pc(idu_pc), .idu_pnpc(idu_pnpc),
    .idu_trap(idu_trap), .idu_cause(idu_cause), .idu_valid(idu_valid),
    .idu_ready(idu_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_fence_i(redirect_fence_i)
  );

  // Advance one cycle; the L1I instruction tracks the presented address.
  task automatic tick();
    @(posedge clock);
    #1;
    l1i_inst = l1i_pc ^ K;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bpu_npc = '0; bpu_taken = 1'b0; l1i_trap = 1'b0; l1i_cause = '0;
    l1i_valid = 1'b0; idu_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; redirect_fence_i = 1'b0; l1i_inst = '0;
    tick(); tick();
    n_checks++; if (l1i_pc !== RST) $display("FAIL rst_l1i_pc got %h want %h", l1i_pc, RST); else n_pass++;
    n_checks++; if (bpu_pc !== RST) $display("FAIL rst_bpu_pc got %h want %h", bpu_pc, RST); else n_pass++;
    n_checks++; if (idu_valid !== 1'b0) $display("FAIL rst_idu_valid got %b want 0", idu_valid); else n_pass++;
    n_checks++; if (idu_pc !== 32'h0 || idu_inst !== 32'h0 || idu_pnpc !== 32'h0)
      $display("FAIL rst_slot got pc=%h inst=%h pnpc=%h want 0", idu_pc, idu_inst, idu_pnpc); else n_pass++;
    n_checks++; if (idu_trap !== 1'b0 || idu_cause !== 32'h0)
      $display("FAIL rst_trap got %b/%h want 0/0", idu_trap, idu_cause); else n_pass++;
    n_checks++; if (l1i_invalid !== 1'b0) $display("FAIL rst_invalid got %b want 0", l1i_invalid); else n_pass++;
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_seq_hits();
    logic [31:0] exp_pc;
    l1i_valid = 1'b1; idu_ready = 1'b1; bpu_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_pc = RST + 32'(4 * i);
      tick();
      n_checks++; if (idu_valid !== 1'b1 || idu_pc !== exp_pc)
        $display("FAIL seq_pc%0d got v=%b pc=%h want 1/%h", i, idu_valid, idu_pc, exp_pc); else n_pass++;
      n_checks++; if (idu_pnpc !== exp_pc + 32'd4 || idu_inst !== (exp_pc ^ K))
        $display("FAIL seq_pay%0d got pnpc=%h inst=%h want %h/%h", i, idu_pnpc, idu_inst, exp_pc + 32'd4, exp_pc ^ K); else n_pass++;
    end
    $display("test_seq_hits done");
  endtask

  task automatic test_taken();
    // pc is now 0x8000_0010
    bpu_taken = 1'b1; bpu_npc = 32'h8000_0100;
    tick();
    bpu_taken = 1'b0;
    n_checks++; if (idu_pc !== 32'h8000_0010 || idu_pnpc !== 32'h8000_0100)
      $display("FAIL taken_slot got pc=%h pnpc=%h want 80000010/80000100", idu_pc, idu_pnpc); else n_pass++;
    n_checks++; if (l1i_pc !== 32'h8000_0100) $display("FAIL taken_l1i_pc got %h want 80000100", l1i_pc); else n_pass++;
    $display("test_taken done");
  endtask

  task automatic test_backpressure();
    idu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0010 || l1i_pc !== 32'h8000_0100)
        $display("FAIL bp_hold%0d got v=%b slot=%h pc=%h want 1/80000010/80000100", i, idu_valid, idu_pc, l1i_pc); else n_pass++;
    end
    idu_ready = 1'b1;
    tick();
    n_checks++; if (idu_pc !== 32'h8000_0100 || l1i_pc !== 32'h8000_0104)
      $display("FAIL bp_resume0 got slot=%h pc=%h want 80000100/80000104", idu_pc, l1i_pc); else n_pass++;
    tick();
    n_checks++; if (idu_pc !== 32'h8000_0104) $display("FAIL bp_resume1 got %h want 80000104", idu_pc); else n_pass++;
    $display("test_backpressure done");
  endtask

  task automatic test_miss_redirect();
    // Hit redirect to 0x20 while the decoder is also taking the slot.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0020;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (idu_valid !== 1'b0 || l1i_pc !== 32'h8000_0020)
      $display("FAIL flush_win got v=%b pc=%h want 0/80000020", idu_valid, l1i_pc); else n_pass++;
    l1i_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (idu_valid !== 1'b0 || l1i_pc !== 32'h8000_0020)
        $display("FAIL discard_wait%0d got v=%b pc=%h want 0/80000020", i, idu_valid, l1i_pc); else n_pass++;
      tick();
    end
    l1i_valid = 1'b1;
    tick();
    n_checks++; if (idu_valid !== 1'b0 || l1i_pc !== 32'h8000_0400)
      $display("FAIL discard_drop got v=%b pc=%h want 0/80000400", idu_valid, l1i_pc); else n_pass++;
    tick();
    n_checks++; if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0400)
      $display("FAIL discard_refetch got v=%b pc=%h want 1/80000400", idu_valid, idu_pc); else n_pass++;
    $display("test_miss_redirect done");
  endtask

  task automatic test_fence();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; redirect_fence_i = 1'b1;
    n_checks++; if (l1i_invalid !== 1'b0) $display("FAIL fence_pre got %b want 0", l1i_invalid); else n_pass++;
    tick();
    redirect_valid = 1'b0; redirect_fence_i = 1'b0;
    n_checks++; if (l1i_invalid !== 1'b1 || l1i_pc !== 32'h8000_0200 || idu_valid !== 1'b0)
      $display("FAIL fence_pulse got inv=%b pc=%h v=%b want 1/80000200/0", l1i_invalid, l1i_pc, idu_valid); else n_pass++;
    tick();
    n_checks++; if (l1i_invalid !== 1'b0 || idu_valid !== 1'b0 || l1i_pc !== 32'h8000_0200)
      $display("FAIL fence_end got inv=%b v=%b pc=%h want 0/0/80000200", l1i_invalid, idu_valid, l1i_pc); else n_pass++;
    tick();
    n_checks++; if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0200 || l1i_invalid !== 1'b0)
      $display("FAIL fence_fetch got v=%b pc=%h inv=%b want 1/80000200/0", idu_valid, idu_pc, l1i_invalid); else n_pass++;
    $display("test_fence done");
  endtask

  task automatic test_trap();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0030;
    tick();
    redirect_valid = 1'b0; l1i_trap = 1'b1; l1i_cause = 32'd1;
    tick();
    l1i_trap = 1'b0; l1i_cause = 32'd0;
    n_checks++; if (idu_valid !== 1'b1 || idu_trap !== 1'b1 || idu_cause !== 32'd1 || idu_pc !== 32'h8000_0030)
      $display("FAIL trap_slot got v=%b t=%b c=%h pc=%h want 1/1/1/80000030", idu_valid, idu_trap, idu_cause, idu_pc); else n_pass++;
    n_checks++; if (l1i_pc !== 32'h8000_0030) $display("FAIL trap_pc_hold got %h want 80000030", l1i_pc); else n_pass++;
    tick();
    n_checks++; if (idu_valid !== 1'b0) $display("FAIL trap_drain got %b want 0", idu_valid); else n_pass++;
    tick();
    n_checks++; if (idu_valid !== 1'b0 || l1i_pc !== 32'h8000_0030)
      $display("FAIL trap_stuck got v=%b pc=%h want 0/80000030", idu_valid, l1i_pc); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0500;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (l1i_pc !== 32'h8000_0500 || idu_valid !== 1'b0)
      $display("FAIL trap_exit got pc=%h v=%b want 80000500/0", l1i_pc, idu_valid); else n_pass++;
    tick();
    n_checks++; if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0500 || idu_trap !== 1'b0)
      $display("FAIL trap_resume got v=%b pc=%h t=%b want 1/80000500/0", idu_valid, idu_pc, idu_trap); else n_pass++;
    $display("test_trap done");
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++; if (idu_pc !== 32'hffff_fffc || idu_pnpc !== 32'h0 || l1i_pc !== 32'h0)
      $display("FAIL wrap got slot=%h pnpc=%h pc=%h want fffffffc/0/0", idu_pc, idu_pnpc, l1i_pc); else n_pass++;
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid_miss();
    l1i_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0600;
    tick();
    redirect_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (l1i_pc !== RST || idu_valid !== 1'b0)
      $display("FAIL async_rst got pc=%h v=%b want %h/0", l1i_pc, idu_valid, RST); else n_pass++;
    tick();
    reset = 1'b1; l1i_valid = 1'b1;
    tick();
    n_checks++; if (idu_valid !== 1'b1 || idu_pc !== RST)
      $display("FAIL rst_refetch got v=%b pc=%h want 1/%h", idu_valid, idu_pc, RST); else n_pass++;
    $display("test_reset_mid_miss done");
  endtask

  initial begin
    test_reset();
    test_seq_hits();
    test_taken();
    test_backpressure();
    test_miss_redirect();
    test_fence();
    test_trap();
    test_wrap();
    test_reset_mid_miss();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
